mdu_ctrl: RTL

Multi-cycle multiply/divide unit controller for the execute stage: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests alongside the single-cycle ALU. It sequences a fixed-latency operation with a down-counter, holds the result in pending registers and commits it to HI/LO. While the unit is busy it raises a stall toward the hazard unit so that no MDU instruction issues.

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// Execute-stage request/response bundle between the pipeline and the MDU controller.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        d_uses_mdu;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_rdata;

  modport master (
    output start, mdu_op, A, B, d_uses_mdu,
    input  busy, stall, hi, lo, mdu_rdata
  );

  modport slave (
    input  start, mdu_op, A, B, d_uses_mdu,
    output busy, stall, hi, lo, mdu_rdata
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: fixed-latency down-counter, pending result
// registers committed to HI/LO when the count expires, and a D-stage stall.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } mdu_op_e;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo, hi_r, lo_r;
  logic [31:0]   a, b, res_hi, res_lo;
  logic [63:0]   prod;
  logic          discard, busy, accept;
  mdu_op_e       op;

  assign a      = bus.A;
  assign b      = bus.B;
  assign op     = mdu_op_e'(bus.mdu_op);
  assign busy   = (cnt != '0);
  assign accept = bus.start & ~busy;

  assign bus.busy      = busy;
  assign bus.stall     = bus.d_uses_mdu & (busy | (bus.start & ~bus.mdu_op[2]));
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.mdu_rdata = (op == OP_MFHI) ? hi_r : lo_r;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    prod   = '0;
    case (op)
      OP_MULT: begin
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {res_hi, res_lo} = prod;
      end
      OP_MULTU: begin
        prod = {32'b0, a} * {32'b0, b};
        {res_hi, res_lo} = prod;
      end
      OP_DIV: begin
        // The most-negative / -1 case overflows native signed division; pin it explicitly.
        if (b == '0) begin
          res_hi = '0;
          res_lo = '0;
        end else if (a == 32'h8000_0000 && b == '1) begin
          res_hi = '0;
          res_lo = 32'h8000_0000;
        end else begin
          res_lo = $signed(a) / $signed(b);
          res_hi = $signed(a) % $signed(b);
        end
      end
      OP_DIVU: begin
        if (b != '0) begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      discard <= 1'b0;
    end else if (accept) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          cnt     <= CW'(MULT_CYCLES);
          discard <= 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          cnt     <= CW'(DIV_CYCLES);
          discard <= (b == '0);
        end
        OP_MTHI: hi_r <= a;
        OP_MTLO: lo_r <= a;
        default: ;
      endcase
    end else if (cnt == CW'(1)) begin
      cnt <= '0;
      if (!discard) begin
        hi_r <= pend_hi;
        lo_r <= pend_lo;
      end
    end else if (busy) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule
